hilo_muldiv_ctrl: RTL and testbench

Sequencer for the HI/LO register pair in the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations and runs a one-cycle multiply or a 32-iteration divide. It stalls the pipeline while a result is pending and issues the single-cycle write strobe into the HI/LO register. It also keeps a shadow copy of HI/LO that serves MFHI/MFLO reads with the newest value.

---
 rtl/hilo_pkg.sv | 33 +++
 rtl/div_iter.sv | 63 ++++++
 rtl/hilo_muldiv_ctrl.sv | 139 +++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared opcodes, FSM states and constants for the HI/LO multiply/divide sequencer.
package hilo_pkg;

    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DIV_CYCLES - 1);
    localparam logic [31:0]      DIVZERO_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } hilo_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } hilo_state_e;

    function automatic logic isHiloOp(input hilo_op_e op);
        return (op != OP_NONE) && (op <= OP_MTLO);
    endfunction

    function automatic logic isMulDivOp(input hilo_op_e op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring radix-2 divider datapath on operand magnitudes; the iteration count
// is owned by the controller, this block only loads, steps and sign-corrects.
module div_iter
    import hilo_pkg::*;
(
    input  logic        clk,
    input  logic        load_i,
    input  logic        step_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        divZero_o,
    output logic [31:0] dividend_o,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);

    logic [31:0] rem_q, quo_q, dsr_q, dvd_q;
    logic        negQuo_q, negRem_q, zero_q;
    logic [31:0] rem_d, quo_d;
    logic [32:0] remShift, trial;
    logic        aNeg, bNeg;
    logic [31:0] aMag, bMag;

    // quot_o/rem_o reflect the step in progress, so the final iteration's result
    // is available in the same cycle the controller commits it.
    always_comb begin
        aNeg     = signed_i & dividend_i[31];
        bNeg     = signed_i & divisor_i[31];
        aMag     = aNeg ? (~dividend_i + 32'd1) : dividend_i;
        bMag     = bNeg ? (~divisor_i + 32'd1) : divisor_i;
        remShift = {rem_q, quo_q[31]};
        trial    = remShift - {1'b0, dsr_q};
        if (trial[32]) begin
            rem_d = remShift[31:0];
            quo_d = {quo_q[30:0], 1'b0};
        end else begin
            rem_d = trial[31:0];
            quo_d = {quo_q[30:0], 1'b1};
        end
        quot_o = negQuo_q ? (~quo_d + 32'd1) : quo_d;
        rem_o  = negRem_q ? (~rem_d + 32'd1) : rem_d;
    end

    always_ff @(posedge clk) begin
        if (load_i) begin
            rem_q    <= '0;
            quo_q    <= aMag;
            dsr_q    <= bMag;
            dvd_q    <= dividend_i;
            negQuo_q <= aNeg ^ bNeg;
            negRem_q <= aNeg;
            zero_q   <= (divisor_i == 32'd0);
        end else if (step_i) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

    assign divZero_o  = zero_q;
    assign dividend_o = dvd_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer: one-cycle multiply, 32-iteration divide, MTHI/MTLO and shadow HI/LO.
// Optional HILO_DIVZERO_FAST_EN: divide by zero resolved on the short multiply path.
module hilo_muldiv_ctrl
    import hilo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall_o,
    output logic        hilo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    hilo_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      hi_q, lo_q;
    logic             hilo_we_q;
    logic             dzFast_q;
    logic [32:0]      mulA_q, mulB_q;

    hilo_op_e    opE;
    logic        accept, isDivOp, isSignedOp, divZeroFast;
    logic [63:0] mulAExt, mulBExt, product;
    logic        divLoad, divStep, divZero;
    logic [31:0] divDividend, divQuot, divRem;

    always_comb begin
        opE        = hilo_op_e'(op);
        accept     = (state_q == ST_IDLE) && op_valid && !flush && isHiloOp(opE);
        isDivOp    = (opE == OP_DIV) || (opE == OP_DIVU);
        isSignedOp = (opE == OP_MULT) || (opE == OP_DIV);
`ifdef HILO_DIVZERO_FAST_EN
        divZeroFast = isDivOp && (src_b == 32'd0);
`else
        divZeroFast = 1'b0;
`endif
        mulAExt = {{31{mulA_q[32]}}, mulA_q};
        mulBExt = {{31{mulB_q[32]}}, mulB_q};
        product = mulAExt * mulBExt;
        divLoad = accept && isDivOp;
        divStep = (state_q == ST_DIV);
        case (state_q)
            ST_IDLE: stall_o = accept && isMulDivOp(opE);
            ST_DIV:  stall_o = (cnt_q != CNT_LAST);
            default: stall_o = 1'b0;
        endcase
    end

    // Operands are captured at accept so a stalled EX stage may change them freely.
    always_ff @(posedge clk) begin
        if (accept) begin
            mulA_q <= {isSignedOp & src_a[31], src_a};
            mulB_q <= {isSignedOp & src_b[31], src_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            hilo_we_q <= 1'b0;
            dzFast_q  <= 1'b0;
        end else begin
            hilo_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        case (opE)
                            OP_MTHI: begin
                                hi_q      <= src_a;
                                hilo_we_q <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo_q      <= src_a;
                                hilo_we_q <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                state_q  <= divZeroFast ? ST_MUL : ST_DIV;
                                cnt_q    <= '0;
                                dzFast_q <= divZeroFast;
                            end
                            default: begin
                                state_q  <= ST_MUL;
                                dzFast_q <= 1'b0;
                            end
                        endcase
                    end
                end
                ST_MUL: begin
                    state_q <= ST_IDLE;
                    if (!flush) begin
                        {hi_q, lo_q} <= dzFast_q ? {mulA_q[31:0], DIVZERO_QUOT} : product;
                        hilo_we_q    <= 1'b1;
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= ST_IDLE;
                        cnt_q     <= '0;
                        hi_q      <= divZero ? divDividend : divRem;
                        lo_q      <= divZero ? DIVZERO_QUOT : divQuot;
                        hilo_we_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    div_iter u_div_iter (
        .clk        (clk),
        .load_i     (divLoad),
        .step_i     (divStep),
        .signed_i   (opE == OP_DIV),
        .dividend_i (src_a),
        .divisor_i  (src_b),
        .divZero_o  (divZero),
        .dividend_o (divDividend),
        .quot_o     (divQuot),
        .rem_o      (divRem)
    );

    assign hilo_we = hilo_we_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: timestamp-based reference model,
// per-cycle output compare, directed literal cases and a randomized phase.
module tb_hilo_muldiv_ctrl;

   localparam logic [2:0] NONE  = 3'd0;
   localparam logic [2:0] MULT  = 3'd1;
   localparam logic [2:0] MULTU = 3'd2;
   localparam logic [2:0] DIV   = 3'd3;
   localparam logic [2:0] DIVU  = 3'd4;
   localparam logic [2:0] MTHI  = 3'd5;
   localparam logic [2:0] MTLO  = 3'd6;
`ifdef HILO_DIVZERO_FAST_EN
   localparam bit FAST_DZ = 1'b1;
`else
   localparam bit FAST_DZ = 1'b0;
`endif

   logic        clk, rst, op_valid, flush;
   logic [2:0]  op;
   logic [31:0] src_a, src_b;
   logic        stall_o, hilo_we;
   logic [31:0] hi_o, lo_o;

   int nCompared = 0;
   int nMismatched = 0;
   int cyc = 0;

   bit          checkEn = 1'b0;
   bit          mBusy = 1'b0;
   bit          expWe = 1'b0;
   bit          expStall;
   logic [31:0] mHi = '0;
   logic [31:0] mLo = '0;
   logic [31:0] pHi, pLo;
   int          mWriteAt, mStallLast;

   hilo_muldiv_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .op_valid (op_valid),
      .op       (op),
      .src_a    (src_a),
      .src_b    (src_b),
      .flush    (flush),
      .stall_o  (stall_o),
      .hilo_we  (hilo_we),
      .hi_o     (hi_o),
      .lo_o     (lo_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [31:0] a,
                                input logic [31:0] b, input logic fl, input logic r);
      op_valid = v;
      op       = o;
      src_a    = a;
      src_b    = b;
      flush    = fl;
      rst      = r;
   endtask

   // Architectural result of a multiply/divide, straight from integer arithmetic.
   function automatic logic [63:0] refResult(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, q, r;
      longint unsigned ua, ub, uq, ur;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      if (o == MULT) return sa * sb;
      if (o == MULTU) return ua * ub;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (o == DIV) begin
         q = sa / sb;
         r = sa % sb;
         return {r[31:0], q[31:0]};
      end
      uq = ua / ub;
      ur = ua % ub;
      return {ur[31:0], uq[31:0]};
   endfunction

   // Model: an accepted op lands its result a fixed number of cycles later unless squashed.
   task automatic modelStep();
      int          c;
      logic [63:0] res;
      c     = cyc;
      cyc   = cyc + 1;
      expWe = 1'b0;
      if (rst) begin
         mBusy   = 1'b0;
         mHi     = '0;
         mLo     = '0;
         checkEn = 1'b1;
      end else if (mBusy) begin
         if (flush) begin
            mBusy = 1'b0;
         end else if (c + 1 == mWriteAt) begin
            mHi   = pHi;
            mLo   = pLo;
            expWe = 1'b1;
            mBusy = 1'b0;
         end
      end else if (op_valid && !flush && op >= MULT && op <= MTLO) begin
         if (op == MTHI) begin
            mHi   = src_a;
            expWe = 1'b1;
         end else if (op == MTLO) begin
            mLo   = src_a;
            expWe = 1'b1;
         end else begin
            res   = refResult(op, src_a, src_b);
            pHi   = res[63:32];
            pLo   = res[31:0];
            mBusy = 1'b1;
            if (op == MULT || op == MULTU || (FAST_DZ && src_b == 32'd0)) begin
               mWriteAt   = c + 2;
               mStallLast = c;
            end else begin
               mWriteAt   = c + 33;
               mStallLast = c + 31;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      modelStep();
   end

   initial forever begin
      @(negedge clk);
      if (checkEn) begin
         expStall = mBusy ? (cyc <= mStallLast) : (op_valid && !flush && op >= MULT && op <= DIVU);
         checkOutput("stall_o", {31'd0, stall_o}, {31'd0, expStall});
         checkOutput("hilo_we", {31'd0, hilo_we}, {31'd0, expWe});
         checkOutput("hi_o", hi_o, mHi);
         checkOutput("lo_o", lo_o, mLo);
      end
   end

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         applyStimulus(1'b0, NONE, '0, '0, 1'b0, 1'b0);
      end
   endtask

   task automatic issueOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int stallLen, output logic [31:0] gotHi, output logic [31:0] gotLo);
      int t0;
      t0       = cyc;
      lat      = -1;
      stallLen = -1;
      gotHi    = '0;
      gotLo    = '0;
      applyStimulus(1'b1, o, a, b, 1'b0, 1'b0);
      for (int n = 0; n < 40 && lat < 0; n++) begin
         @(negedge clk);
         if (stall_o) stallLen = cyc - t0;
         if (hilo_we) begin
            lat   = cyc - t0;
            gotHi = hi_o;
            gotLo = lo_o;
         end
         @(posedge clk);
         #1;
         applyStimulus(1'b0, NONE, '0, '0, 1'b0, 1'b0);
      end
   endtask

   function automatic logic [31:0] randOperand();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(1, 20));
         4:       return ~32'($urandom_range(0, 19));
         default: return $urandom;
      endcase
   endfunction

   task automatic checkDirected(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                input int wantLat, input int wantStall, input logic [31:0] wantHi, input logic [31:0] wantLo);
      int          lat, sl;
      logic [31:0] gh, gl;
      issueOp(o, a, b, lat, sl, gh, gl);
      checkOutput({name, " latency"}, 32'(lat), 32'(wantLat));
      checkOutput({name, " stall"}, 32'(sl), 32'(wantStall));
      checkOutput({name, " hi"}, gh, wantHi);
      checkOutput({name, " lo"}, gl, wantLo);
   endtask

   initial begin
      int weCount;
      applyStimulus(1'b0, NONE, '0, '0, 1'b0, 1'b1);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      applyStimulus(1'b0, NONE, '0, '0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("reset hi", hi_o, 32'd0);
      checkOutput("reset lo", lo_o, 32'd0);
      checkOutput("reset we", {31'd0, hilo_we}, 32'd0);
      checkOutput("reset stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk);
      #1;

      checkDirected("mult -3*5", MULT, 32'hFFFF_FFFD, 32'd5, 2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      checkDirected("divu 100/7", DIVU, 32'd100, 32'd7, 33, 31, 32'd2, 32'd14);
      checkDirected("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 33, 31, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      checkDirected("divu by 0", DIVU, 32'h0000_1234, 32'd0, FAST_DZ ? 2 : 33, FAST_DZ ? 0 : 31,
                    32'h0000_1234, 32'hFFFF_FFFF);
      checkDirected("div overflow", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 31, 32'd0, 32'h8000_0000);
      checkDirected("multu max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0, 32'hFFFF_FFFE, 32'h0000_0001);

      applyStimulus(1'b1, MTHI, 32'h0000_AAAA, '0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("mthi stall", {31'd0, stall_o}, 32'd0);
      checkOutput("mthi we at T", {31'd0, hilo_we}, 32'd0);
      @(posedge clk);
      #1;
      applyStimulus(1'b1, MTLO, 32'h0000_5555, '0, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("mthi we", {31'd0, hilo_we}, 32'd1);
      checkOutput("mthi hi", hi_o, 32'h0000_AAAA);
      idleCycles(1);
      @(negedge clk);
      checkOutput("mtlo we", {31'd0, hilo_we}, 32'd1);
      checkOutput("mtlo hi", hi_o, 32'h0000_AAAA);
      checkOutput("mtlo lo", lo_o, 32'h0000_5555);
      idleCycles(1);

      applyStimulus(1'b1, DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
      idleCycles(9);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, NONE, '0, '0, 1'b1, 1'b0);
      idleCycles(1);
      @(negedge clk);
      checkOutput("flush stall", {31'd0, stall_o}, 32'd0);
      checkOutput("flush we", {31'd0, hilo_we}, 32'd0);
      checkOutput("flush hi", hi_o, 32'h0000_AAAA);
      checkOutput("flush lo", lo_o, 32'h0000_5555);
      weCount = 0;
      for (int i = 0; i < 35; i++) begin
         @(negedge clk);
         if (hilo_we) weCount++;
      end
      checkOutput("flush no write", 32'(weCount), 32'd0);
      idleCycles(1);

      applyStimulus(1'b1, DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      idleCycles(9);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, NONE, '0, '0, 1'b0, 1'b1);
      idleCycles(1);
      @(negedge clk);
      checkOutput("rst stall", {31'd0, stall_o}, 32'd0);
      checkOutput("rst we", {31'd0, hilo_we}, 32'd0);
      checkOutput("rst hi", hi_o, 32'd0);
      checkOutput("rst lo", lo_o, 32'd0);
      weCount = 0;
      for (int i = 0; i < 35; i++) begin
         @(negedge clk);
         if (hilo_we) weCount++;
      end
      checkOutput("rst no write", 32'(weCount), 32'd0);

      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         #1;
         applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 6)), randOperand(), randOperand(),
                       $urandom_range(0, 95) == 0, $urandom_range(0, 299) == 0);
      end
      idleCycles(40);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
